// File: rtl/core_cluster_pkg.sv
// Shared opcode layout for the core cluster: misc-opcode field positions,
// the misc prefix, mask-update modes and the per-core operation codes.
package core_cluster_pkg;

    localparam int OPCODE_W = 16;

    localparam int PREFIX_HI   = 15;
    localparam int PREFIX_LO   = 14;
    localparam int IDX_HI      = 13;
    localparam int IDX_LO      = 9;
    localparam int STORE_BIT   = 7;
    localparam int MODE_HI     = 6;
    localparam int MODE_LO     = 5;
    localparam int OUT_REQ_BIT = 4;

    localparam logic [1:0] MISC_PREFIX = 2'b11;

    typedef enum logic [1:0] {
        MODE_KEEP = 2'b00,
        MODE_SET  = 2'b01,
        MODE_ALL  = 2'b10,
        MODE_CLR  = 2'b11
    } mode_e;

    // Core-local operations share the prefix field; 2'b11 belongs to the cluster.
    typedef enum logic [1:0] {
        CORE_LOAD_IMM = 2'b00,
        CORE_ADD_GLOB = 2'b01,
        CORE_LOAD_ID  = 2'b10,
        CORE_NONE     = 2'b11
    } core_op_e;

    typedef struct packed {
        logic [4:0] idx;
        logic       store;
        mode_e      mode;
        logic       out_req;
    } misc_fields_t;

    function automatic misc_fields_t decode_misc(input logic [OPCODE_W-1:0] op);
        misc_fields_t f;
        f.idx     = op[IDX_HI:IDX_LO];
        f.store   = op[STORE_BIT];
        f.mode    = mode_e'(op[MODE_HI:MODE_LO]);
        f.out_req = op[OUT_REQ_BIT];
        return f;
    endfunction

endpackage

// File: rtl/core_cluster_core.sv
// Single processing core: accumulator updated by core-local opcodes,
// exposes the low datapath bits of its accumulator for cluster stores.
module core
    import core_cluster_pkg::*;
#(
    parameter int CORE_ID    = 0,
    parameter int BIT_WIDTH  = 8,
    parameter int NR_GLOBALS = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             execute_i,
    input  logic [OPCODE_W-1:0]              opcode_i,
    input  logic [NR_GLOBALS*BIT_WIDTH-1:0]  globals_i,
    output logic [BIT_WIDTH-1:0]             acc_lo_o
);

    localparam int ACC_W = 2 * BIT_WIDTH;

    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [BIT_WIDTH-1:0] glob_sel;

    // Out-of-range global index reads as zero.
    always_comb begin
        glob_sel = '0;
        for (int g = 0; g < NR_GLOBALS; g++) begin
            if (int'(opcode_i[IDX_HI:IDX_LO]) == g) begin
                glob_sel = globals_i[g*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (execute_i) begin
            case (core_op_e'(opcode_i[PREFIX_HI:PREFIX_LO]))
                CORE_LOAD_IMM: acc_d = ACC_W'(opcode_i[IDX_HI:0]);
                CORE_ADD_GLOB: acc_d = acc_q + ACC_W'(glob_sel);
                CORE_LOAD_ID:  acc_d = ACC_W'(CORE_ID);
                default:       acc_d = acc_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_lo_o = acc_q[BIT_WIDTH-1:0];

endmodule

// File: rtl/core_cluster_serializer.sv
// MSB-first parallel-to-serial shifter with a down-counting bit counter;
// last_o marks the final shift cycle so a reload can follow without a gap.
module bit_serializer #(
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [BIT_WIDTH-1:0] data_i,
    output logic                 busy_o,
    output logic                 last_o,
    output logic                 valid_o,
    output logic                 bit_o
);

    localparam int CNT_W = $clog2(BIT_WIDTH + 1);

    logic [BIT_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shift_d = data_i;
            cnt_d   = CNT_W'(BIT_WIDTH);
        end else if (cnt_q != '0) begin
            shift_d = shift_q << 1;
            cnt_d   = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o  = (cnt_q != '0);
    assign last_o  = (cnt_q == CNT_W'(1));
    assign valid_o = busy_o;
    assign bit_o   = busy_o & shift_q[BIT_WIDTH-1];

endmodule

// File: rtl/core_cluster.sv
// Cluster of cores sharing global registers, a core-enable mask and a serial
// readout port; misc opcodes (prefix 2'b11) drive store, mask and readout.
module core_cluster
    import core_cluster_pkg::*;
#(
    parameter int NR_CORES   = 4,
    parameter int BIT_WIDTH  = 8,
    parameter int NR_GLOBALS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         opcode,
    input  logic                execute,
    output logic                busy,
    output logic                overrun,
    output logic [NR_CORES-1:0] core_mask,
    output logic                valid_bit,
    output logic                output_bit
);

    logic [NR_CORES-1:0]             mask_q, mask_d;
    logic [BIT_WIDTH-1:0]            glob_q [NR_GLOBALS];
    logic [BIT_WIDTH-1:0]            glob_d [NR_GLOBALS];
    logic                            overrun_q, overrun_d;
    logic [NR_GLOBALS*BIT_WIDTH-1:0] glob_flat;
    logic [BIT_WIDTH-1:0]            acc_lo [NR_CORES];

    misc_fields_t         f;
    logic                 is_misc;
    logic                 idx_ok;
    logic                 store_hit;
    logic [BIT_WIDTH-1:0] store_data;
    logic [BIT_WIDTH-1:0] cap_data;
    logic                 ser_load, ser_busy, ser_last;

    assign f       = decode_misc(opcode);
    assign is_misc = execute && (opcode[PREFIX_HI:PREFIX_LO] == MISC_PREFIX);
    assign idx_ok  = int'(f.idx) < NR_GLOBALS;

    always_comb begin
        glob_flat = '0;
        for (int g = 0; g < NR_GLOBALS; g++) begin
            glob_flat[g*BIT_WIDTH +: BIT_WIDTH] = glob_q[g];
        end
    end

    for (genvar y = 0; y < NR_CORES; y++) begin : g_core
        core #(
            .CORE_ID    (y),
            .BIT_WIDTH  (BIT_WIDTH),
            .NR_GLOBALS (NR_GLOBALS)
        ) u_core (
            .clk_i     (clk),
            .rst_i     (rst),
            .execute_i (execute & mask_q[y]),
            .opcode_i  (opcode),
            .globals_i (glob_flat),
            .acc_lo_o  (acc_lo[y])
        );
    end

    // Descending scan so the lowest enabled core wins the store.
    always_comb begin
        store_hit  = 1'b0;
        store_data = '0;
        for (int y = NR_CORES - 1; y >= 0; y--) begin
            if (mask_q[y]) begin
                store_hit  = 1'b1;
                store_data = acc_lo[y];
            end
        end
    end

    // Readout captures the register value before any same-opcode store.
    always_comb begin
        cap_data = '0;
        for (int g = 0; g < NR_GLOBALS; g++) begin
            if (int'(f.idx) == g) begin
                cap_data = glob_q[g];
            end
        end
    end

    always_comb begin
        glob_d    = glob_q;
        mask_d    = mask_q;
        overrun_d = overrun_q;
        ser_load  = 1'b0;
        if (is_misc) begin
            if (f.store && store_hit) begin
                for (int g = 0; g < NR_GLOBALS; g++) begin
                    if (int'(f.idx) == g) glob_d[g] = store_data;
                end
            end
            case (f.mode)
                MODE_SET: begin
                    for (int y = 0; y < NR_CORES; y++) begin
                        if (int'(f.idx) == y) mask_d[y] = 1'b1;
                    end
                end
                MODE_ALL: mask_d = '1;
                MODE_CLR: begin
                    for (int y = 0; y < NR_CORES; y++) begin
                        if (int'(f.idx) == y) mask_d[y] = 1'b0;
                    end
                end
                default: mask_d = mask_q;
            endcase
            if (f.out_req && idx_ok) begin
                if (ser_busy && !ser_last) begin
                    overrun_d = 1'b1;
                end else begin
                    ser_load = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q    <= '1;
            overrun_q <= 1'b0;
            for (int g = 0; g < NR_GLOBALS; g++) glob_q[g] <= '0;
        end else begin
            mask_q    <= mask_d;
            overrun_q <= overrun_d;
            for (int g = 0; g < NR_GLOBALS; g++) glob_q[g] <= glob_d[g];
        end
    end

    bit_serializer #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_serializer (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (ser_load),
        .data_i  (cap_data),
        .busy_o  (ser_busy),
        .last_o  (ser_last),
        .valid_o (valid_bit),
        .bit_o   (output_bit)
    );

    assign busy      = ser_busy;
    assign overrun   = overrun_q;
    assign core_mask = mask_q;

endmodule

// File: tb/tb_core_cluster.sv
// Self-checking bench for core_cluster: directed scenarios plus a randomized
// run against a queue-based behavioural model of the cluster.
module tb_core_cluster;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] opcode;
    logic        execute;
    logic        busy, overrun, valid_bit, output_bit;
    logic [3:0]  core_mask;

    int n_cmp = 0;
    int n_bad = 0;

    core_cluster #(.NR_CORES(4), .BIT_WIDTH(8), .NR_GLOBALS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .execute    (execute),
        .busy       (busy),
        .overrun    (overrun),
        .core_mask  (core_mask),
        .valid_bit  (valid_bit),
        .output_bit (output_bit)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_acc [4];
    logic [7:0]  m_glob [8];
    logic [3:0]  m_mask;
    bit          m_ovr;
    bit          m_q [$];

    function automatic logic [15:0] misc_op(input int idx, input int st, input int md, input int orq);
        logic [15:0] r;
        r = 16'hC000;
        r[13:9] = 5'(idx);
        r[7]    = st[0];
        r[6:5]  = 2'(md);
        r[4]    = orq[0];
        return r;
    endfunction

    task automatic model_step(input bit r, input bit ex, input logic [15:0] op);
        int idx, sz, low;
        logic [7:0] cap;
        if (r) begin
            for (int i = 0; i < 4; i++) m_acc[i] = '0;
            for (int i = 0; i < 8; i++) m_glob[i] = '0;
            m_mask = 4'hF;
            m_ovr = 0;
            m_q.delete();
            return;
        end
        sz = m_q.size();
        if (sz > 0) void'(m_q.pop_front());
        if (!ex) return;
        idx = int'(op[13:9]);
        if (op[15:14] != 2'b11) begin
            for (int y = 0; y < 4; y++) begin
                if (m_mask[y]) begin
                    case (op[15:14])
                        2'b00: m_acc[y] = {2'b00, op[13:0]};
                        2'b01: m_acc[y] = m_acc[y] + ((idx < 8) ? {8'h00, m_glob[idx]} : 16'h0);
                        default: m_acc[y] = 16'(y);
                    endcase
                end
            end
            return;
        end
        cap = (idx < 8) ? m_glob[idx] : 8'h00;
        low = -1;
        for (int y = 3; y >= 0; y--) if (m_mask[y]) low = y;
        if (op[7] && idx < 8 && low >= 0) m_glob[idx] = m_acc[low][7:0];
        case (op[6:5])
            2'b01: if (idx < 4) m_mask[idx] = 1'b1;
            2'b10: m_mask = 4'hF;
            2'b11: if (idx < 4) m_mask[idx] = 1'b0;
            default: ;
        endcase
        if (op[4] && idx < 8) begin
            if (sz <= 1) begin
                for (int b = 7; b >= 0; b--) m_q.push_back(cap[b]);
            end else begin
                m_ovr = 1;
            end
        end
    endtask

    // Drive one cycle of stimulus; outputs are stable at the following negedge.
    task automatic cyc(input bit r, input bit ex, input logic [15:0] op);
        rst = r; execute = ex; opcode = op;
        @(posedge clk);
        model_step(r, ex, op);
        @(negedge clk);
        rst = 0; execute = 0; opcode = '0;
    endtask

    task automatic test_reset;
        cyc(1, 1, 16'hC040);
        cyc(1, 0, 16'h0);
        n_cmp++; if (core_mask !== 4'b1111) begin n_bad++; $display("FAIL reset_mask: got %b want 1111", core_mask); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        n_cmp++; if (valid_bit !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_bit); end
        n_cmp++; if (output_bit !== 1'b0) begin n_bad++; $display("FAIL reset_bit: got %b want 0", output_bit); end
    endtask

    task automatic test_mask;
        cyc(0, 1, 16'hC040);
        n_cmp++; if (core_mask !== 4'b1111) begin n_bad++; $display("FAIL mask_all: got %b want 1111", core_mask); end
        cyc(0, 1, 16'hC460);
        n_cmp++; if (core_mask !== 4'b1011) begin n_bad++; $display("FAIL mask_clr2: got %b want 1011", core_mask); end
        cyc(0, 1, misc_op(6, 0, 3, 0));
        n_cmp++; if (core_mask !== 4'b1011) begin n_bad++; $display("FAIL mask_clr_oob: got %b want 1011", core_mask); end
        cyc(0, 1, misc_op(2, 0, 1, 0));
        n_cmp++; if (core_mask !== 4'b1111) begin n_bad++; $display("FAIL mask_set2: got %b want 1111", core_mask); end
    endtask

    task automatic check_stream(input string name, input logic [7:0] exp_v);
        // Caller has just issued the request; first bit is visible now.
        for (int k = 0; k < 8; k++) begin
            if (k > 0) cyc(0, 0, 16'h0);
            n_cmp++;
            if (valid_bit !== 1'b1 || output_bit !== exp_v[7-k]) begin
                n_bad++;
                $display("FAIL %s bit%0d: got v=%b b=%b want v=1 b=%b", name, 7-k, valid_bit, output_bit, exp_v[7-k]);
            end
        end
        cyc(0, 0, 16'h0);
        n_cmp++; if (busy !== 1'b0 || valid_bit !== 1'b0 || output_bit !== 1'b0) begin
            n_bad++; $display("FAIL %s end: got busy=%b v=%b b=%b want 0 0 0", name, busy, valid_bit, output_bit);
        end
    endtask

    task automatic test_store;
        cyc(0, 1, misc_op(0, 0, 3, 0));
        cyc(0, 1, misc_op(2, 0, 3, 0));
        cyc(0, 1, misc_op(3, 0, 3, 0));
        cyc(0, 1, 16'h0155);
        cyc(0, 1, misc_op(3, 0, 1, 0));
        cyc(0, 1, misc_op(1, 0, 3, 0));
        cyc(0, 1, 16'h03AA);
        cyc(0, 1, misc_op(1, 0, 1, 0));
        n_cmp++; if (core_mask !== 4'b1010) begin n_bad++; $display("FAIL store_mask: got %b want 1010", core_mask); end
        cyc(0, 1, 16'hC680);
        cyc(0, 1, misc_op(3, 0, 0, 1));
        check_stream("store_g3", 8'h55);
    endtask

    task automatic test_serial;
        cyc(0, 1, 16'h00A5);
        cyc(0, 1, misc_op(3, 1, 0, 0));
        cyc(0, 1, misc_op(3, 0, 0, 1));
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL serial_busy: got %b want 1", busy); end
        check_stream("serial_a5", 8'hA5);
    endtask

    task automatic test_back_to_back;
        logic [7:0] a, b;
        a = 8'hA5; b = 8'h3C;
        cyc(0, 1, 16'h003C);
        cyc(0, 1, misc_op(1, 1, 0, 0));
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_ovr_pre: got %b want 0", overrun); end
        cyc(0, 1, misc_op(3, 0, 0, 1));
        for (int k = 1; k < 16; k++) begin
            if (k == 4)      cyc(0, 1, misc_op(5, 0, 0, 1));
            else if (k == 8) cyc(0, 1, misc_op(1, 0, 0, 1));
            else             cyc(0, 0, 16'h0);
            n_cmp++;
            if (valid_bit !== 1'b1 || output_bit !== ((k < 8) ? a[7-k] : b[15-k])) begin
                n_bad++;
                $display("FAIL b2b k%0d: got v=%b b=%b want v=1 b=%b", k, valid_bit, output_bit, (k < 8) ? a[7-k] : b[15-k]);
            end
            if (k == 4) begin
                n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL b2b_overrun: got %b want 1", overrun); end
            end
        end
        cyc(0, 0, 16'h0);
        n_cmp++; if (busy !== 1'b0 || overrun !== 1'b1) begin
            n_bad++; $display("FAIL b2b_end: got busy=%b ovr=%b want 0 1", busy, overrun);
        end
    endtask

    task automatic test_store_and_read;
        cyc(0, 1, 16'h005A);
        cyc(0, 1, 16'hC690);
        check_stream("same_old", 8'hA5);
        cyc(0, 1, misc_op(3, 0, 0, 1));
        check_stream("same_new", 8'h5A);
    endtask

    task automatic test_reset_mid;
        cyc(0, 1, misc_op(0, 0, 3, 0));
        cyc(0, 1, misc_op(3, 0, 0, 1));
        for (int k = 1; k <= 4; k++) cyc(0, 0, 16'h0);
        n_cmp++; if (valid_bit !== 1'b1 || output_bit !== 1'b1) begin
            n_bad++; $display("FAIL rmid_bit3: got v=%b b=%b want 1 1", valid_bit, output_bit);
        end
        cyc(1, 1, misc_op(3, 0, 0, 1));
        n_cmp++; if (valid_bit !== 1'b0 || busy !== 1'b0 || output_bit !== 1'b0) begin
            n_bad++; $display("FAIL rmid_abort: got v=%b busy=%b b=%b want 0 0 0", valid_bit, busy, output_bit);
        end
        n_cmp++; if (core_mask !== 4'b1111 || overrun !== 1'b0) begin
            n_bad++; $display("FAIL rmid_state: got mask=%b ovr=%b want 1111 0", core_mask, overrun);
        end
        cyc(0, 1, misc_op(3, 0, 0, 1));
        for (int k = 0; k < 8; k++) begin
            if (k == 2)      cyc(0, 1, misc_op(9, 1, 0, 1));
            else if (k > 0)  cyc(0, 0, 16'h0);
            n_cmp++; if (valid_bit !== 1'b1 || output_bit !== 1'b0) begin
                n_bad++; $display("FAIL rmid_zero k%0d: got v=%b b=%b want 1 0", k, valid_bit, output_bit);
            end
        end
        cyc(0, 0, 16'h0);
        n_cmp++; if (overrun !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rmid_oob_req: got ovr=%b busy=%b want 0 0", overrun, busy);
        end
    endtask

    task automatic test_random;
        logic [15:0] op;
        bit r, ex;
        logic [8:0] got, exp_v;
        bit ev;
        cyc(1, 0, 16'h0);
        for (int n = 0; n < 2000; n++) begin
            r  = ($urandom_range(0, 149) == 0);
            ex = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) == 1) begin
                op = misc_op($urandom_range(0, 11), $urandom_range(0, 1),
                             $urandom_range(0, 3), ($urandom_range(0, 2) == 0) ? 1 : 0);
            end else begin
                op = 16'($urandom);
                op[15:14] = 2'($urandom_range(0, 2));
            end
            cyc(r, ex, op);
            ev = (m_q.size() != 0);
            exp_v = {ev, m_ovr, m_mask, ev, ev ? m_q[0] : 1'b0, 1'b0};
            got   = {busy, overrun, core_mask, valid_bit, output_bit, 1'b0};
            n_cmp++;
            if (got !== exp_v) begin
                n_bad++;
                $display("FAIL random n%0d: got busy,ovr,mask,v,b=%b want %b", n, got[8:1], exp_v[8:1]);
            end
        end
    endtask

    initial begin
        rst = 1; execute = 0; opcode = '0;
        @(negedge clk);
        test_reset();
        test_mask();
        test_store();
        test_serial();
        test_back_to_back();
        test_store_and_read();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
